// File: rtl/pb_debounce_if.sv
// pb_debounce_if: raw pushbutton inputs and conditioned outputs of the two-channel debouncer
interface pb_debounce_if;
    logic pbl_raw;
    logic pbr_raw;
    logic pbl;
    logic pbr;
    logic pbl_pulse;
    logic pbr_pulse;
    logic both_pulse;
    logic stuck;
    modport master (
        output pbl_raw, pbr_raw,
        input  pbl, pbr, pbl_pulse, pbr_pulse, both_pulse, stuck
    );
    modport slave (
        input  pbl_raw, pbr_raw,
        output pbl, pbr, pbl_pulse, pbr_pulse, both_pulse, stuck
    );
endinterface

// File: rtl/pb_debounce.sv
// pb_debounce: two-channel pushbutton synchronizer/debouncer with press pulses; define STUCK_DETECT_EN to add stuck-button detection
module pb_debounce #(
    parameter int DB_CYCLES    = 50000,
    parameter int STUCK_CYCLES = 2**26
) (
    input logic          clk,
    input logic          rst,
    pb_debounce_if.slave pb
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    typedef enum logic [2:0] {ARM, IDLE, PWAIT, PRESSED, RWAIT} state_t;
    logic [1:0] s1, s, lvl_q, lvl_d, pul_q, pul_d, flag;
    logic both_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s      <= '0;
            lvl_q  <= '0;
            pul_q  <= '0;
            both_q <= 1'b0;
        end else begin
            s1     <= {pb.pbr_raw, pb.pbl_raw};
            s      <= s1;
            lvl_q  <= lvl_d;
            pul_q  <= pul_d;
            both_q <= &pul_d;
        end
    end
`ifdef STUCK_DETECT_EN
    localparam int HW = $clog2(STUCK_CYCLES) + 1;
    localparam logic [HW-1:0] HMAX = HW'(STUCK_CYCLES);
    logic [1:0] idle;
`endif
    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t st, st_d;
        logic [CW-1:0] cnt, cnt_d;
        logic lv_d, pu_d;
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= ARM;
                cnt <= '0;
            end else begin
                st  <= st_d;
                cnt <= cnt_d;
            end
        end
        always_comb begin
            st_d  = st;
            cnt_d = '0;
            lv_d  = lvl_q[c];
            pu_d  = 1'b0;
            case (st)
                ARM: begin
                    if (!s[c] && cnt == LAST) st_d = IDLE;
                    else if (!s[c]) cnt_d = cnt + 1'b1;
                end
                IDLE: st_d = s[c] ? PWAIT : IDLE;
                PWAIT: begin
                    if (!s[c]) st_d = IDLE;
                    else if (cnt == LAST) begin
                        st_d = PRESSED;
                        lv_d = 1'b1;
                        pu_d = !flag[c];
                    end else cnt_d = cnt + 1'b1;
                end
                PRESSED: st_d = s[c] ? PRESSED : RWAIT;
                RWAIT: begin
                    if (s[c]) st_d = PRESSED;
                    else if (cnt == LAST) begin
                        st_d = IDLE;
                        lv_d = 1'b0;
                    end else cnt_d = cnt + 1'b1;
                end
                default: st_d = ARM;
            endcase
        end
        assign lvl_d[c] = lv_d;
        assign pul_d[c] = pu_d;
`ifdef STUCK_DETECT_EN
        logic [HW-1:0] hold;
        logic fl;
        // flags only drop once both channels are fully idle, so a stuck channel stays muted while either is held
        always_ff @(posedge clk) begin
            if (rst) begin
                hold <= '0;
                fl   <= 1'b0;
            end else begin
                hold <= !lvl_q[c] ? '0 : (hold == HMAX ? hold : hold + 1'b1);
                fl   <= &idle ? 1'b0 : (hold == HMAX ? 1'b1 : fl);
            end
        end
        assign idle[c] = st == IDLE;
        assign flag[c] = fl;
`endif
    end
`ifdef STUCK_DETECT_EN
    assign pb.stuck = |flag;
`else
    logic unused_cfg;
    assign unused_cfg = ^STUCK_CYCLES;
    assign flag       = '0;
    assign pb.stuck   = 1'b0;
`endif
    assign pb.pbl        = lvl_q[0];
    assign pb.pbr        = lvl_q[1];
    assign pb.pbl_pulse  = pul_q[0];
    assign pb.pbr_pulse  = pul_q[1];
    assign pb.both_pulse = both_q;
endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: directed and random stimulus against a run-length model of the debouncer
module tb_pb_debounce;
    localparam int DB = 8;
    localparam int ST = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int npl = 0, npr = 0, nboth = 0;
    pb_debounce_if pb();
    pb_debounce #(.DB_CYCLES(DB), .STUCK_CYCLES(ST)) dut (.clk(clk), .rst(rst), .pb(pb));
    always #5 clk = ~clk;

    // model: synced samples, armed after DB zeros, level flips after DB+1 disagreeing samples
    bit m_s1[2], m_s2[2], armed[2], lvl[2], pul[2], flg[2];
    int zrun[2], drun[2], hold[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit raw0, input bit raw1);
        bit raw[2];
        bit fo[2];
        bit idle_all;
        raw[0] = raw0;
        raw[1] = raw1;
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; armed[c] = 0; lvl[c] = 0; pul[c] = 0;
                flg[c] = 0; zrun[c] = 0; drun[c] = 0; hold[c] = 0;
            end
            return;
        end
        idle_all = 1;
        for (int c = 0; c < 2; c++) begin
            idle_all &= armed[c] && !lvl[c] && drun[c] == 0;
            fo[c] = flg[c];
        end
`ifdef STUCK_DETECT_EN
        for (int c = 0; c < 2; c++) begin
            flg[c]  = idle_all ? 1'b0 : (hold[c] == ST ? 1'b1 : flg[c]);
            hold[c] = lvl[c] ? (hold[c] == ST ? ST : hold[c] + 1) : 0;
        end
`endif
        for (int c = 0; c < 2; c++) begin
            pul[c] = 0;
            if (!armed[c]) begin
                zrun[c] = m_s2[c] ? 0 : zrun[c] + 1;
                if (zrun[c] == DB) begin
                    armed[c] = 1;
                    drun[c] = 0;
                end
            end else begin
                drun[c] = (m_s2[c] != lvl[c]) ? drun[c] + 1 : 0;
                if (drun[c] == DB + 1) begin
                    lvl[c] = m_s2[c];
                    pul[c] = m_s2[c] && !fo[c];
                    drun[c] = 0;
                end
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
        end
    endtask

    task automatic step();
        bit r, a, b;
        r = rst;
        a = pb.pbl_raw;
        b = pb.pbr_raw;
        @(posedge clk);
        model_step(r, a, b);
        #1;
        check("pbl", pb.pbl, lvl[0]);
        check("pbr", pb.pbr, lvl[1]);
        check("pbl_pulse", pb.pbl_pulse, pul[0]);
        check("pbr_pulse", pb.pbr_pulse, pul[1]);
        check("both_pulse", pb.both_pulse, pul[0] & pul[1]);
        check("stuck", pb.stuck, flg[0] | flg[1]);
        npl   += int'(pb.pbl_pulse);
        npr   += int'(pb.pbr_pulse);
        nboth += int'(pb.both_pulse);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        bit rr[2];
        int rem[2];
        pb.pbl_raw = 0;
        pb.pbr_raw = 0;
        rst = 1;
        run(3);
        check("rst_pbl", pb.pbl, 0);
        check("rst_pulse", pb.pbl_pulse, 0);
        rst = 0;
        run(12);
        // press latency counted in edges, the first being the one that samples the raw input
        pb.pbl_raw = 1;
        npl = 0;
        n = 0;
        while (npl == 0 && n < 30) begin
            step();
            n++;
        end
        check("press_latency", n, 1 + 2 + DB);
        check("press_level", pb.pbl, 1);
        run(5);
        check("press_once", npl, 1);
        pb.pbl_raw = 0;
        run(15);
        npl = 0;
        repeat (2) begin
            pb.pbl_raw = 1;
            run(2);
            pb.pbl_raw = 0;
            run(2);
        end
        check("burst_quiet", npl, 0);
        pb.pbl_raw = 1;
        run(30);
        check("burst_pulses", npl, 1);
        pb.pbl_raw = 0;
        pb.pbr_raw = 1;
        rst = 1;
        run(3);
        rst = 0;
        npr = 0;
        run(30);
        check("held_thru_rst", npr, 0);
        pb.pbr_raw = 0;
        run(12);
        pb.pbr_raw = 1;
        run(20);
        check("rearm_press", npr, 1);
        pb.pbr_raw = 0;
        run(20);
        npl = 0; npr = 0; nboth = 0;
        pb.pbl_raw = 1;
        pb.pbr_raw = 1;
        run(20);
        check("both_same", nboth, 1);
        check("both_l", npl, 1);
        check("both_r", npr, 1);
        pb.pbl_raw = 0;
        pb.pbr_raw = 0;
        run(20);
        nboth = 0;
        pb.pbl_raw = 1;
        step();
        pb.pbr_raw = 1;
        run(20);
        check("skew_both", nboth, 0);
        pb.pbr_raw = 0;
        npl = 0;
        pb.pbl_raw = 0;
        run(4);
        pb.pbl_raw = 1;
        run(3);
        pb.pbl_raw = 0;
        check("rwait_bounce_lvl", pb.pbl, 1);
        n = 0;
        while (pb.pbl && n < 30) begin
            step();
            n++;
        end
        check("release_latency", n, 1 + 2 + DB);
        check("rwait_no_pulse", npl, 0);
        run(10);
`ifdef STUCK_DETECT_EN
        pb.pbl_raw = 1;
        run(100);
        check("stuck_set", pb.stuck, 1);
        pb.pbl_raw = 0;
        run(25);
        check("stuck_clear", pb.stuck, 0);
`else
        pb.pbl_raw = 1;
        run(100);
        check("stuck_off", pb.stuck, 0);
        pb.pbl_raw = 0;
        run(25);
`endif
        rr[0] = 0; rr[1] = 0;
        rem[0] = 1; rem[1] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    rr[c] = !rr[c];
                    rem[c] = int'($urandom_range(1, 24));
                end
            end
            pb.pbl_raw = rr[0];
            pb.pbr_raw = rr[1];
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 0;
        pb.pbl_raw = 0;
        pb.pbr_raw = 0;
        run(30);
        check("final_idle", {pb.pbl, pb.pbr}, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
